// File: rtl/uart_cmd_parser.sv
// Frame controller behind the UART RX: assembles HEADER/ADDR/DATA_H/DATA_L/CHK frames
// into config writes on a valid/ready port, dropping bad, stalled or overrunning frames.
module uart_cmd_parser #(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] HEADER  = 8'h55,
    parameter int                TIMEOUT = 26040,
    parameter int                TO_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     byte_in,
    input  logic                  byte_vld,
    output logic [DATA_W-1:0]     cfg_addr,
    output logic [2*DATA_W-1:0]   cfg_wdata,
    output logic                  cfg_vld,
    input  logic                  cfg_rdy,
    output logic                  err_chk,
    output logic                  err_to,
    output logic                  err_ovf,
    output logic                  busy
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DH, S_DL, S_CHK, S_OUT} state_t;

    state_t            state, state_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] addr_q, dh_q, dl_q;
    logic [DATA_W-1:0] sum;
    logic              in_frame, to_hit, chk_ok;
    logic              err_chk_d, err_to_d, err_ovf_d, busy_d, vld_d, load_cfg;

    assign sum      = addr_q + dh_q + dl_q;
    assign chk_ok   = (byte_in == sum);
    assign in_frame = (state == S_ADDR) || (state == S_DH) || (state == S_DL) || (state == S_CHK);
    // A byte on the terminal count wins over the timeout.
    assign to_hit   = in_frame && !byte_vld && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (byte_vld && byte_in == HEADER) state_nxt = S_ADDR;
            S_ADDR: if (byte_vld) state_nxt = S_DH; else if (to_hit) state_nxt = S_IDLE;
            S_DH:   if (byte_vld) state_nxt = S_DL; else if (to_hit) state_nxt = S_IDLE;
            S_DL:   if (byte_vld) state_nxt = S_CHK; else if (to_hit) state_nxt = S_IDLE;
            S_CHK: begin
                if (byte_vld)    state_nxt = chk_ok ? S_OUT : S_IDLE;
                else if (to_hit) state_nxt = S_IDLE;
            end
            S_OUT:  if (cfg_rdy) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        err_chk_d = (state == S_CHK) && byte_vld && !chk_ok;
        err_to_d  = to_hit;
        err_ovf_d = (state == S_OUT) && byte_vld;
        busy_d    = (state_nxt != S_IDLE);
        vld_d     = (state_nxt == S_OUT);
        load_cfg  = (state == S_CHK) && (state_nxt == S_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (byte_vld || to_hit || !in_frame) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            dh_q   <= '0;
            dl_q   <= '0;
        end else if (byte_vld) begin
            case (state)
                S_ADDR:  addr_q <= byte_in;
                S_DH:    dh_q   <= byte_in;
                S_DL:    dl_q   <= byte_in;
                default: ;
            endcase
        end
    end

    // Output regs hold the last accepted frame so data stays stable while cfg_vld waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            cfg_vld   <= 1'b0;
            err_chk   <= 1'b0;
            err_to    <= 1'b0;
            err_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (load_cfg) begin
                cfg_addr  <= addr_q;
                cfg_wdata <= {dh_q, dl_q};
            end
            cfg_vld <= vld_d;
            err_chk <= err_chk_d;
            err_to  <= err_to_d;
            err_ovf <= err_ovf_d;
            busy    <= busy_d;
        end
    end

endmodule
